// File: rtl/uart_tx_monitor.sv
// 8N1 UART receiver with a small valid/ready output FIFO and saturating error counters.
// Define UART_TX_MONITOR_PARITY_EN to decode 8E1 frames and add parity_err/parity_err_cnt.
module uart_tx_monitor #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_line,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] overrun_cnt,
`ifdef UART_TX_MONITOR_PARITY_EN
  output logic             parity_err,
  output logic [CNT_W-1:0] parity_err_cnt,
`endif
  output logic             busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_MONITOR_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state, state_n;
  logic            sync1, rx_s;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            tick;
  logic            push_req, ferr_req;
  logic            push_q;
  logic [7:0]      push_data;
`ifdef UART_TX_MONITOR_PARITY_EN
  logic            par_bit, par_n;
  logic            perr_req;
`endif

  // Two-flop synchronizer; idle-high reset so reset release never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_line;
      rx_s  <= sync1;
    end
  end

  assign tick = (timer == '0);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n   = state;
    timer_n   = tick ? timer : timer - 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    ferr_req  = 1'b0;
`ifdef UART_TX_MONITOR_PARITY_EN
    par_n     = par_bit;
    perr_req  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          timer_n = T_HALF;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            timer_n   = T_FULL;
            bit_idx_n = 3'd0;
            state_n   = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_n = {rx_s, shreg[7:1]};
          timer_n = T_FULL;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_MONITOR_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_MONITOR_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_n   = rx_s;
          timer_n = T_FULL;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid-stop-bit lets the next start edge be caught immediately
        if (tick) begin
          state_n = S_IDLE;
          if (!rx_s) begin
            ferr_req = 1'b1;
`ifdef UART_TX_MONITOR_PARITY_EN
          end else if (^{shreg, par_bit}) begin
            perr_req = 1'b1;
`endif
          end else begin
            push_req = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      push_q    <= 1'b0;
      push_data <= 8'h00;
      frame_err <= 1'b0;
`ifdef UART_TX_MONITOR_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      push_q    <= push_req;
      frame_err <= ferr_req;
      if (push_req) push_data <= shreg;
`ifdef UART_TX_MONITOR_PARITY_EN
      par_bit   <= par_n;
`endif
    end
  end

`ifdef UART_TX_MONITOR_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err     <= 1'b0;
      parity_err_cnt <= '0;
    end else begin
      parity_err <= perr_req;
      if (perr_req && parity_err_cnt != '1) parity_err_cnt <= parity_err_cnt + 1'b1;
    end
  end
`endif

  // FIFO: extra pointer MSB separates full from empty
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, wr_en, ovr_req;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign wr_en     = push_q && (!full || pop);
  assign ovr_req   = push_q && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun       <= 1'b0;
      overrun_cnt   <= '0;
      frame_err_cnt <= '0;
    end else begin
      overrun <= ovr_req;
      if (ovr_req && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      if (ferr_req && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
    end
  end

endmodule
